// File: rtl/avalon_st_source_interface.sv
// Avalon-ST source stage: streams RGB565 pixels to the next Qsys element.
// The output register OUT and the skid register SKD together form a 2-entry buffer.
// This gives full throughput and leaves no combinational path from ready_src to ready_in.
// startofpacket/endofpacket come from a pixel counter and travel with each pixel.
// Optional feature macro: FRAME_CHECK_EN. When defined, sop_in/eop_in are compared
// against the counter, sop_in resyncs the counter, and frame_err reports mismatches.
module avalon_st_source_interface #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FRAME_W = 320,
    parameter int unsigned FRAME_H = 240,
    parameter int unsigned CNT_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              sop_in,
    input  logic              eop_in,
    output logic [DATA_W-1:0] data_src,
    output logic              valid_src,
    input  logic              ready_src,
    output logic              startofpacket_src,
    output logic              endofpacket_src,
    output logic              frame_err
);

    localparam int unsigned     PIX_LAST = FRAME_W * FRAME_H - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_LAST);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } pix_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    pix_t             out_q;
    pix_t             skd_q;
    pix_t             in_pix_c;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt_c;
    logic             acc_c;
    logic             drn_c;
    logic             cnt_first_c;
    logic             cnt_last_c;

    // Handshake qualifiers, incoming pixel tagging and next counter value
    always_comb begin
        acc_c         = valid_in && ready_in;
        drn_c         = valid_src && ready_src;
        cnt_first_c   = (cnt == '0);
        cnt_last_c    = (cnt == CNT_LAST);
        in_pix_c.data = data_in;
        in_pix_c.sop  = cnt_first_c;
        in_pix_c.eop  = cnt_last_c;
        cnt_nxt_c     = cnt_last_c ? '0 : cnt + CNT_W'(1);
`ifdef FRAME_CHECK_EN
        // A pipeline frame-start makes this pixel index 0 of a new frame
        if (sop_in) begin
            in_pix_c.sop = 1'b1;
            in_pix_c.eop = (CNT_LAST == '0);
            cnt_nxt_c    = (CNT_LAST == '0) ? '0 : CNT_W'(1);
        end
`endif
    end

    // Pixel position within the frame, advanced on every accepted pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (acc_c) begin
            cnt <= cnt_nxt_c;
        end
    end

    // Skid-buffer FSM: OUT drives the source bus, SKD catches a pixel during a stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            out_q     <= '0;
            skd_q     <= '0;
            valid_src <= 1'b0;
            ready_in  <= 1'b0;
        end else begin
            ready_in <= 1'b1;
            case (state)
                EMPTY: begin
                    if (acc_c) begin
                        out_q     <= in_pix_c;
                        valid_src <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (acc_c && !drn_c) begin
                        skd_q    <= in_pix_c;
                        ready_in <= 1'b0;
                        state    <= FULL;
                    end else if (acc_c && drn_c) begin
                        out_q <= in_pix_c;
                    end else if (drn_c) begin
                        valid_src <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (drn_c) begin
                        out_q <= skd_q;
                        state <= ONE;
                    end else begin
                        ready_in <= 1'b0;
                    end
                end
                default: begin
                    valid_src <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

    assign data_src          = out_q.data;
    assign startofpacket_src = out_q.sop;
    assign endofpacket_src   = out_q.eop;

`ifdef FRAME_CHECK_EN
    // Sticky framing error: pipeline tags disagree with the pixel counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
        end else if (acc_c && ((sop_in != cnt_first_c) || (eop_in != cnt_last_c))) begin
            frame_err <= 1'b1;
        end
    end
`else
    logic unused_tags;
    assign unused_tags = sop_in ^ eop_in;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_st_source_interface.sv
// Self-checking bench for avalon_st_source_interface (FRAME_W=4, FRAME_H=2).
// Directed sequences plus a reference queue of {data, sop, eop} checked at every transfer.
module tb_avalon_st_source_interface;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FRAME_W = 4;
    localparam int unsigned FRAME_H = 2;
    localparam int unsigned CNT_W   = 17;
    localparam int          LAST    = FRAME_W * FRAME_H - 1;
`ifdef FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              valid_in = 1'b0;
    logic              ready_in;
    logic              sop_in = 1'b0;
    logic              eop_in = 1'b0;
    logic [DATA_W-1:0] data_src;
    logic              valid_src;
    logic              ready_src = 1'b0;
    logic              startofpacket_src;
    logic              endofpacket_src;
    logic              frame_err;

    avalon_st_source_interface #(
        .DATA_W (DATA_W),
        .FRAME_W(FRAME_W),
        .FRAME_H(FRAME_H),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .valid_in         (valid_in),
        .ready_in         (ready_in),
        .sop_in           (sop_in),
        .eop_in           (eop_in),
        .data_src         (data_src),
        .valid_src        (valid_src),
        .ready_src        (ready_src),
        .startofpacket_src(startofpacket_src),
        .endofpacket_src  (endofpacket_src),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              s;
        logic              e;
    } ent_t;

    ent_t              exp_q[$];
    int                m_cnt = 0;
    int                n_out = 0;
    bit                prev_stall = 1'b0;
    logic [DATA_W+1:0] prev = '0;

    // Reference queue: predicts tags on acceptance, checks each transfer and stall stability
    always @(negedge clk) begin : mon
        ent_t e;
        if (!reset) begin
            exp_q.delete();
            m_cnt      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(valid_src), 32'd1);
                check("hold_payload", 32'({data_src, startofpacket_src, endofpacket_src}), 32'(prev));
            end
            if (valid_src && ready_src) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(data_src), 32'(e.d));
                    check("sb_sop", 32'(startofpacket_src), 32'(e.s));
                    check("sb_eop", 32'(endofpacket_src), 32'(e.e));
                end
                n_out++;
            end
            prev_stall = valid_src && !ready_src;
            prev       = {data_src, startofpacket_src, endofpacket_src};
            if (valid_in && ready_in) begin
                e.d = data_in;
                if (FC && sop_in) begin
                    e.s   = 1'b1;
                    e.e   = (LAST == 0);
                    m_cnt = (LAST == 0) ? 0 : 1;
                end else begin
                    e.s   = (m_cnt == 0);
                    e.e   = (m_cnt == LAST);
                    m_cnt = (m_cnt == LAST) ? 0 : m_cnt + 1;
                end
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        int n0;

        // Reset values
        step();
        step();
        check("rst_valid_src", 32'(valid_src), 32'd0);
        check("rst_ready_in", 32'(ready_in), 32'd0);
        check("rst_data_src", 32'(data_src), 32'd0);
        check("rst_sop", 32'(startofpacket_src), 32'd0);
        check("rst_eop", 32'(endofpacket_src), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b1;
        step();
        check("rel_ready_in", 32'(ready_in), 32'd1);

        // 1: stream 1..9 at full rate, SOP on 1 and 9, EOP on 8
        ready_src = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            valid_in = 1'b1;
            data_in  = 16'(i);
            step();
            check("t1_valid", 32'(valid_src), 32'd1);
            check("t1_data", 32'(data_src), 32'(i));
            check("t1_sop", 32'(startofpacket_src), 32'((i == 1) || (i == 9)));
            check("t1_eop", 32'(endofpacket_src), 32'(i == 8));
        end
        valid_in = 1'b0;
        step();
        check("t1_idle", 32'(valid_src), 32'd0);

        // 2: backpressure fills the skid register, third pixel waits
        ready_src = 1'b0;
        valid_in  = 1'b1;
        data_in   = 16'h0001;
        step();
        check("t2_ready_one", 32'(ready_in), 32'd1);
        data_in = 16'h0002;
        step();
        check("t2_ready_full", 32'(ready_in), 32'd0);
        check("t2_hold1", 32'(data_src), 32'h0001);
        data_in = 16'h0003;
        step();
        step();
        check("t2_ready_stall", 32'(ready_in), 32'd0);
        check("t2_hold2", 32'(data_src), 32'h0001);
        ready_src = 1'b1;
        step();
        check("t2_out2", 32'(data_src), 32'h0002);
        step();
        check("t2_out3", 32'(data_src), 32'h0003);
        valid_in = 1'b0;
        step();
        check("t2_idle", 32'(valid_src), 32'd0);

        // 3: simultaneous accept and drain keeps the stage in ONE
        n0 = n_out;
        for (int i = 0; i <= 20; i++) begin
            valid_in = 1'b1;
            data_in  = 16'(16'h0100 + i);
            step();
            check("t3_valid", 32'(valid_src), 32'd1);
            check("t3_ready", 32'(ready_in), 32'd1);
            check("t3_data", 32'(data_src), 32'(16'h0100 + i));
        end
        valid_in = 1'b0;
        step();
        step();
        check("t3_count", 32'(n_out - n0), 32'd21);

        // 4: async reset while FULL mid-frame, first pixel afterwards is SOP
        ready_src = 1'b0;
        valid_in  = 1'b1;
        data_in   = 16'h0050;
        step();
        data_in = 16'h0051;
        step();
        check("t4_full", 32'(ready_in), 32'd0);
        reset    = 1'b0;
        valid_in = 1'b0;
        #1;
        check("t4_async_valid", 32'(valid_src), 32'd0);
        check("t4_async_ready", 32'(ready_in), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check("t4_rel_ready", 32'(ready_in), 32'd1);
        ready_src = 1'b1;
        valid_in  = 1'b1;
        data_in   = 16'h00AA;
        step();
        check("t4_data", 32'(data_src), 32'h00AA);
        check("t4_sop", 32'(startofpacket_src), 32'd1);
        check("t4_eop", 32'(endofpacket_src), 32'd0);
        valid_in = 1'b0;
        step();

        // 5: sop_in on the third pixel of a fresh frame
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check("t5_err_clear", 32'(frame_err), 32'd0);
        valid_in = 1'b1;
        sop_in   = 1'b1;
        data_in  = 16'h0501;
        step();
        check("t5_sop1", 32'(startofpacket_src), 32'd1);
        sop_in  = 1'b0;
        data_in = 16'h0502;
        step();
        check("t5_err_p2", 32'(frame_err), 32'd0);
        sop_in  = 1'b1;
        data_in = 16'h0503;
        step();
        check("t5_data3", 32'(data_src), 32'h0503);
        check("t5_sop3", 32'(startofpacket_src), 32'(FC));
        check("t5_err_set", 32'(frame_err), 32'(FC));
        sop_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            data_in = 16'(16'h0503 + k);
            step();
            check("t5_eop", 32'(endofpacket_src), 32'(FC ? (k == 7) : (k == 5)));
            check("t5_err_sticky", 32'(frame_err), 32'(FC));
        end
        valid_in = 1'b0;
        step();

        // 6: random valid/ready, reference queue checks every transfer
        n0 = n_out;
        for (int c = 0; c < 10000; c++) begin
            valid_in  = 1'($urandom_range(0, 1));
            ready_src = 1'($urandom_range(0, 1));
            data_in   = 16'($urandom);
            step();
        end
        valid_in  = 1'b0;
        ready_src = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        check("t6_progress", 32'(n_out - n0 > 1000), 32'd1);
        check("t6_idle", 32'(valid_src), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
